drp_master: RTL
===============

DRP_MASTER -- requirements
Module: drp_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, max clk cycles to wait for drprdy after a DRP strobe (legal 2..65535).
REQ-002 clk  input  1  DRP clock; all logic in this domain; same clock drives the transceiver drpclk_in.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid and req_ready both high on a rising edge.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  10  DRP address.
REQ-008 req_wdata  input  16  write data.
REQ-009 req_wmask  input  16  bit-enable; 16'hFFFF = full write, otherwise read-modify-write; ignored for reads.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready both high.
REQ-012 rsp_rdata  output  16  read data (pre-write value for RMW, 0 for full write or timeout).
REQ-013 rsp_timeout  output  1  transaction aborted by timeout.
REQ-014 drpen, drpwe  output  1 each  DRP strobes toward transceiver.
REQ-015 drpaddr  output  10; drpdi  output  16; drpdo  input  16; drprdy  input  1  DRP bus.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 stray_rdy  output  1  sticky flag, drprdy seen with no access outstanding; cleared only by reset.

Function
REQ-018 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP; all outputs registered.
REQ-019 req_ready SHALL be high only in IDLE; addr, wdata, wmask, write latched on acceptance.
REQ-020 Read or RMW: IDLE -> RD_ISSUE; full write: IDLE -> WR_ISSUE.
REQ-021 drpen SHALL be high for exactly one cycle, the cycle after acceptance (or after read completion for RMW write phase); drpwe high in that cycle only for WR_ISSUE.
REQ-022 drpaddr and drpdi SHALL be stable from the strobe cycle until drprdy or timeout.
REQ-023 RD_WAIT on drprdy: capture drpdo; read -> RESP; RMW -> WR_ISSUE with drpdi = (drpdo AND NOT mask) OR (wdata AND mask).
REQ-024 WR_WAIT on drprdy -> RESP, rsp_timeout = 0.
REQ-025 Timeout counter (16 bit) cleared at each strobe, increments each wait cycle; reaching TIMEOUT_CYCLES without drprdy -> RESP with rsp_timeout = 1, rsp_rdata = 0; RMW aborts without write phase.
REQ-026 drprdy in the same cycle the counter expires SHALL count as success, not timeout.
REQ-027 drprdy in the strobe cycle itself SHALL be ignored and set stray_rdy (transceiver ready is never same-cycle).
REQ-028 RESP: rsp_valid held high with rsp_rdata and rsp_timeout stable until rsp_ready; then IDLE, rsp_valid low next cycle.
REQ-029 Minimum turnaround: req_ready SHALL reassert the cycle after the response handshake; no back-to-back overlap of DRP accesses.
REQ-030 drprdy in IDLE or RESP SHALL set stray_rdy and not alter state or response.
REQ-031 Nominal read latency: accept at cycle 0, drpen at 1, drprdy at N, rsp_valid at N+1.

Reset
REQ-032 While rst_n low: state IDLE, req_ready, rsp_valid, rsp_timeout, drpen, drpwe, busy, stray_rdy = 0; drpaddr, drpdi, rsp_rdata = 0; counter = 0.
REQ-033 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-transaction SHALL drop drpen/drpwe immediately; no response produced; a drprdy arriving after reset release SHALL only set stray_rdy.

Verification
REQ-035 Read addr 0x07C, responder drprdy 3 cycles after strobe with drpdo 0xBEEF -> one drpen pulse, drpwe 0, rsp_rdata 0xBEEF, rsp_timeout 0, rsp_valid 4 cycles after strobe cycle count rule of REQ-031.
REQ-036 Full write addr 0x063 data 0x1234 mask 0xFFFF -> single drpen+drpwe pulse, drpdi 0x1234, rsp_rdata 0, rsp_timeout 0.
REQ-037 RMW addr 0x063 wdata 0x00F0 mask 0x00FF, drpdo returns 0xAB0C -> read strobe then write strobe, drpdi 0xABF0, rsp_rdata 0xAB0C.
REQ-038 TIMEOUT_CYCLES = 8, responder silent -> rsp_timeout 1 exactly 8 wait cycles after strobe, rsp_rdata 0; RMW issues no write; drprdy on cycle 8 instead -> success.
REQ-039 rsp_ready held low 20 cycles -> rsp_valid and data stable, req_ready low, new req_valid not accepted; stray drprdy in RESP sets stray_rdy only.
REQ-040 rst_n pulsed low while in RD_WAIT -> drpen 0, no rsp_valid, late drprdy sets stray_rdy, subsequent read completes normally.

Source files
------------

// File: rtl/drp_master_if.sv
// -----------------------------------------------------------------------------
// drp_master_if
//
// Purpose:
//   Bundles the request/response handshake of a DRP access engine and the
//   transceiver-side DRP bus into one interface.
//
// Signal summary:
//   Request  : req_valid, req_ready, req_write, req_addr[9:0],
//              req_wdata[15:0], req_wmask[15:0]
//   Response : rsp_valid, rsp_ready, rsp_rdata[15:0], rsp_timeout
//   DRP bus  : drpen, drpwe, drpaddr[9:0], drpdi[15:0], drpdo[15:0], drprdy
//
// Modports:
//   master : the DRP access engine (drives req_ready, rsp_*, DRP strobes).
//   slave  : the user of the engine plus the DRP responder side
//            (drives requests, rsp_ready, drpdo, drprdy).
// -----------------------------------------------------------------------------
interface drp_master_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic [15:0] req_wmask;

  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;

  // DRP bus toward the transceiver
  logic        drpen;
  logic        drpwe;
  logic [9:0]  drpaddr;
  logic [15:0] drpdi;
  logic [15:0] drpdo;
  logic        drprdy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  rsp_ready,
    input  drpdo, drprdy,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_timeout,
    output drpen, drpwe, drpaddr, drpdi
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    output rsp_ready,
    output drpdo, drprdy,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_timeout,
    input  drpen, drpwe, drpaddr, drpdi
  );
endinterface

// File: rtl/drp_master.sv
// -----------------------------------------------------------------------------
// drp_master
//
// Purpose:
//   Turns single read / write / read-modify-write requests into Xilinx-style
//   DRP accesses. One access is outstanding at a time. Every DRP strobe is
//   guarded by a timeout counter so a silent transceiver cannot hang the
//   requester. drprdy pulses that arrive when no access is waiting are
//   flagged on the sticky stray_rdy output.
//
// Parameters:
//   TIMEOUT_CYCLES : wait cycles allowed after a strobe before the access is
//                    aborted (legal 2..65535).
//
// Ports:
//   clk       : DRP clock, also drives the transceiver drpclk.
//   rst_n     : asynchronous active-low reset.
//   bus_if    : drp_master_if.master - request, response and DRP bus.
//   busy      : high whenever the engine is not idle.
//   stray_rdy : sticky, drprdy seen with no access waiting; reset clears it.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module drp_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  drp_master_if.master bus_if,
  output logic         busy,
  output logic         stray_rdy
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] FULL_MASK     = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rmw_q, rmw_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] wmask_q, wmask_d;
  logic [15:0] rdata_q, rdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        drpen_q, drpen_d;
  logic        drpwe_q, drpwe_d;
  logic [9:0]  drpaddr_q, drpaddr_d;
  logic [15:0] drpdi_q, drpdi_d;
  logic        busy_q, busy_d;
  logic        stray_q, stray_d;

  logic [15:0] cnt_inc;
  logic        cnt_expired;
  logic [15:0] merged_data;

  assign cnt_inc     = cnt_q + 16'd1;
  // The wait cycle that brings the count to the limit is the last one allowed.
  assign cnt_expired = (cnt_inc == TIMEOUT_LIMIT);

  // Read-modify-write merge: masked bits come from the request, the rest
  // from the value just read back.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_merge
      assign merged_data[gi] = wmask_q[gi] ? wdata_q[gi] : bus_if.drpdo[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      rmw_q         <= 1'b0;
      wdata_q       <= 16'd0;
      wmask_q       <= 16'd0;
      rdata_q       <= 16'd0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 16'd0;
      rsp_timeout_q <= 1'b0;
      drpen_q       <= 1'b0;
      drpwe_q       <= 1'b0;
      drpaddr_q     <= 10'd0;
      drpdi_q       <= 16'd0;
      busy_q        <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rmw_q         <= rmw_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      rdata_q       <= rdata_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      drpen_q       <= drpen_d;
      drpwe_q       <= drpwe_d;
      drpaddr_q     <= drpaddr_d;
      drpdi_q       <= drpdi_d;
      busy_q        <= busy_d;
      stray_q       <= stray_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rmw_d         = rmw_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    drpaddr_d     = drpaddr_q;
    drpdi_d       = drpdi_q;
    stray_d       = stray_q;
    // strobes are single-cycle pulses, only raised on the entry edge
    drpen_d       = 1'b0;
    drpwe_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.drprdy) begin
          stray_d = 1'b1;
        end
        // req_ready_q is low on the first cycle after reset, so it must
        // qualify the handshake rather than the state alone.
        if (bus_if.req_valid && req_ready_q) begin
          wdata_d   = bus_if.req_wdata;
          wmask_d   = bus_if.req_wmask;
          drpaddr_d = bus_if.req_addr;
          cnt_d     = 16'd0;
          drpen_d   = 1'b1;
          if (bus_if.req_write && (bus_if.req_wmask == FULL_MASK)) begin
            rmw_d   = 1'b0;
            drpwe_d = 1'b1;
            drpdi_d = bus_if.req_wdata;
            state_d = ST_WR_ISSUE;
          end else begin
            rmw_d   = bus_if.req_write;
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        // A transceiver never answers in the strobe cycle itself.
        if (bus_if.drprdy) begin
          stray_d = 1'b1;
        end
        cnt_d   = 16'd0;
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // drprdy wins over an expiring counter.
        if (bus_if.drprdy) begin
          rdata_d = bus_if.drpdo;
          if (rmw_q) begin
            drpen_d = 1'b1;
            drpwe_d = 1'b1;
            drpdi_d = merged_data;
            cnt_d   = 16'd0;
            state_d = ST_WR_ISSUE;
          end else begin
            rsp_rdata_d   = bus_if.drpdo;
            rsp_timeout_d = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
          end
        end else if (cnt_expired) begin
          // RMW aborts here without a write phase.
          rsp_rdata_d   = 16'd0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WR_ISSUE: begin
        if (bus_if.drprdy) begin
          stray_d = 1'b1;
        end
        cnt_d   = 16'd0;
        state_d = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (bus_if.drprdy) begin
          // RMW reports the pre-write value, a full write reports zero.
          rsp_rdata_d   = rmw_q ? rdata_q : 16'd0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_expired) begin
          rsp_rdata_d   = 16'd0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        if (bus_if.drprdy) begin
          stray_d = 1'b1;
        end
        if (bus_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Derived from the next state so they line up with the state register.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_if.req_ready   = req_ready_q;
  assign bus_if.rsp_valid   = rsp_valid_q;
  assign bus_if.rsp_rdata   = rsp_rdata_q;
  assign bus_if.rsp_timeout = rsp_timeout_q;
  assign bus_if.drpen       = drpen_q;
  assign bus_if.drpwe       = drpwe_q;
  assign bus_if.drpaddr     = drpaddr_q;
  assign bus_if.drpdi       = drpdi_q;
  assign busy               = busy_q;
  assign stray_rdy          = stray_q;

endmodule
